mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single byte-wide RAM port between instruction fetch (IF) and the load/store
//  stage (MEM). Serialises each request into 1/2/4 single-byte RAM accesses, assembles
//  little-endian read data, and raises per-requester stall requests for the stall controller
//  that drives stall_state. MEM has fixed priority over IF; an in-flight IF fetch is abortable.
// PARAMETERS
//  ADDR_W    32  RAM/requester address width
//  IF_BYTES  4   bytes per instruction fetch
// PORTS
//  clk          in   1       system clock; all state updates on posedge
//  rst          in   1       synchronous reset, active-low (0 = reset, sampled at posedge clk)
//  if_req       in   1       fetch request; level, held until if_ready; drop = abort
//  if_addr      in   ADDR_W  fetch byte address; stable while if_req high
//  mem_req      in   1       load/store request; level, held until mem_ready
//  mem_we       in   1       1 = store, 0 = load
//  mem_size     in   2       0 byte, 1 half, 2 word, 3 reserved (treated as word)
//  mem_addr     in   ADDR_W  load/store byte address
//  mem_wdata    in   32      store data; byte k = mem_wdata[8k+7:8k]
//  ram_din      in   8       RAM read data; valid the cycle after ram_addr issued
//  ram_addr     out  ADDR_W  RAM byte address
//  ram_wr       out  1       RAM write strobe (1 = write ram_dout at ram_addr)
//  ram_dout     out  8       RAM write data
//  if_ready     out  1       1-cycle pulse: if_inst valid
//  if_inst      out  32      assembled instruction; held until next fetch completes
//  mem_ready    out  1       1-cycle pulse: load/store complete
//  mem_rdata    out  32      load data, zero-extended; held until next load completes
//  stallreq_if  out  1       if_req & ~if_ready (combinational)
//  stallreq_mem out  1       mem_req & ~mem_ready (combinational)
//  busy         out  1       state != IDLE
// BEHAVIOUR
//  - Reset (rst=0 at posedge): state IDLE, cnt 0, if_ready/mem_ready 0, if_inst/mem_rdata 0;
//    ram_wr is 0, ram_addr/ram_dout 0 while IDLE. Reset mid-transaction abandons it.
//  - States IDLE, IF_RD, MEM_RD, MEM_WR; registers base, N (byte count), cnt (0..4).
//  - IDLE grant (cycle T): if either *_ready high this cycle -> no grant (suppresses re-grant
//    of a request being dropped). Else mem_req -> MEM_WR/MEM_RD (N from mem_size);
//    else if_req -> IF_RD (N=IF_BYTES); base latched, cnt=0.
//  - RAM drive (combinational from regs): ram_addr = base+cnt, mod 2^ADDR_W (wraps);
//    ram_wr = (state==MEM_WR); ram_dout = wdata byte cnt; outside valid issue cycles
//    ram_addr=0, ram_wr=0, ram_dout=0.
//  - Read: issue cnt=0..N-1; on cycles cnt=1..N capture ram_din into byte cnt-1;
//    cnt increments each cycle. At the edge ending cnt=N: ready<=1, state<=IDLE.
//    Latency: ready high in cycle T+N+2 (word fetch: T+6; byte load: T+3).
//  - Write: issue cnt=0..N-1, one byte per cycle; at edge ending cnt=N-1: mem_ready<=1,
//    IDLE. Latency: ready in T+N+1 (word store: T+5).
//  - Ready pulses last exactly one cycle. Unwritten upper bytes of mem_rdata are 0.
//  - IF abort: if_req low at any posedge in IF_RD -> IDLE next cycle, no if_ready,
//    if_inst unchanged. Abort and new request in same cycle: new request granted next
//    IDLE cycle (no same-cycle re-grant).
//  - mem_req is not abortable: deassertion during MEM_* ignored; transaction completes.
//  - Requests arriving while busy wait; MEM preempts a pending (not in-flight) IF.
//  - Never more than one transaction in flight; no RAM access issued in IDLE.
// TESTING
//  1 Word fetch: if_req, if_addr=0x100, RAM[0x100..103]=13,05,10,00 -> ram_addr 100..103
//    cycles T+1..T+4, if_ready only at T+6, if_inst=0x00100513.
//  2 Simultaneous if_req+mem_req (load byte 0x2000, RAM=0xFF) -> MEM first, mem_rdata=
//    0x000000FF at T+3; IF granted at T+4 (not T+3), if_ready at T+10.
//  3 Store half 0xABCD1234 @0x3FFFF -> writes 0x34@0x3FFFF, 0x12@0x40000, ram_wr 2 cycles,
//    mem_ready at T+3; upper bytes never written.
//  4 Fetch abort: drop if_req at T+3 -> IDLE at T+4, no if_ready, if_inst keeps old value;
//    new if_req at T+4 granted normally.
//  5 Wrap: load word @0xFFFFFFFE -> addresses FFFFFFFE, FFFFFFFF, 00000000, 00000001.
//  6 rst=0 at T+3 of a word store -> all outputs reset next cycle, ram_wr=0, no mem_ready.

Source files
------------

// File: rtl/mem_arbiter.sv
// Byte-wide RAM port arbiter between instruction fetch (IF) and load/store (MEM).
// Each request is split into 1/2/4 single-byte RAM accesses. Read data is assembled
// little-endian. MEM has fixed priority over IF, and an in-flight IF fetch may be aborted.
//
// Ports:
//   clk, rst              clock, synchronous active-low reset
//   if_req/if_addr        fetch request (level) and byte address
//   mem_req/mem_we/...    load/store request, direction, size, address, store data
//   ram_addr/ram_wr/...   byte RAM port; ram_din is valid one cycle after ram_addr
//   if_ready/if_inst      fetch-complete pulse and held instruction word
//   mem_ready/mem_rdata   load/store-complete pulse and held zero-extended load data
//   stallreq_if/_mem      per-requester stall requests
//   busy                  a transaction is in flight
module mem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned IF_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [7:0]        ram_din,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  output logic              if_ready,
  output logic [31:0]       if_inst,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  output logic              stallreq_if,
  output logic              stallreq_mem,
  output logic              busy
);

  localparam logic [2:0] IfBytes = 3'(IF_BYTES);

  typedef enum logic [1:0] {StIdle, StIfRd, StMemRd, StMemWr} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [2:0]        nbytes_q, nbytes_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       buf_q, buf_d;
  logic              if_ready_q, if_ready_d;
  logic              mem_ready_q, mem_ready_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;

  logic        issue;
  logic [1:0]  byte_idx;
  logic [31:0] rd_data;

  // RAM port, driven purely from registered state.
  always_comb begin
    issue    = (state_q != StIdle) && (cnt_q < nbytes_q);
    ram_addr = '0;
    ram_wr   = 1'b0;
    ram_dout = '0;
    if (issue) begin
      ram_addr = base_q + ADDR_W'(cnt_q);
      if (state_q == StMemWr) begin
        ram_wr   = 1'b1;
        ram_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
      end
    end
  end

  // Buffer with this cycle's returning byte merged in; byte cnt-1 arrives while cnt = 1..N.
  always_comb begin
    byte_idx = 2'(cnt_q - 3'd1);
    rd_data  = buf_q;
    if (cnt_q != 3'd0) begin
      rd_data[{byte_idx, 3'b000} +: 8] = ram_din;
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    nbytes_d    = nbytes_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;

    unique case (state_q)
      StIdle: begin
        // A ready pulse means that requester is still dropping its request: no grant.
        if (!if_ready_q && !mem_ready_q) begin
          if (mem_req) begin
            state_d = mem_we ? StMemWr : StMemRd;
            base_d  = mem_addr;
            wdata_d = mem_wdata;
            cnt_d   = 3'd0;
            buf_d   = '0;
            unique case (mem_size)
              2'd0:    nbytes_d = 3'd1;
              2'd1:    nbytes_d = 3'd2;
              default: nbytes_d = 3'd4;
            endcase
          end else if (if_req) begin
            state_d  = StIfRd;
            base_d   = if_addr;
            nbytes_d = IfBytes;
            cnt_d    = 3'd0;
            buf_d    = '0;
          end
        end
      end
      StIfRd: begin
        if (!if_req) begin
          state_d = StIdle;
        end else begin
          buf_d = rd_data;
          if (cnt_q == nbytes_q) begin
            if_inst_d  = rd_data;
            if_ready_d = 1'b1;
            state_d    = StIdle;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      StMemRd: begin
        buf_d = rd_data;
        if (cnt_q == nbytes_q) begin
          mem_rdata_d = rd_data;
          mem_ready_d = 1'b1;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StMemWr: begin
        if (cnt_q == nbytes_q - 3'd1) begin
          mem_ready_d = 1'b1;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      base_q      <= '0;
      nbytes_q    <= '0;
      cnt_q       <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if_inst_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      nbytes_q    <= nbytes_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign if_ready     = if_ready_q;
  assign mem_ready    = mem_ready_q;
  assign if_inst      = if_inst_q;
  assign mem_rdata    = mem_rdata_q;
  assign stallreq_if  = if_req & ~if_ready_q;
  assign stallreq_mem = mem_req & ~mem_ready_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [7:0]  ram_din;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic        if_ready;
  logic [31:0] if_inst;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        stallreq_if;
  logic        stallreq_mem;
  logic        busy;

  int n_asrt = 0;
  int n_fail = 0;
  logic [31:0] last_inst = '0;
  logic [31:0] last_rd   = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .IF_BYTES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_size     (mem_size),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .ram_din      (ram_din),
    .ram_addr     (ram_addr),
    .ram_wr       (ram_wr),
    .ram_dout     (ram_dout),
    .if_ready     (if_ready),
    .if_inst      (if_inst),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .stallreq_if  (stallreq_if),
    .stallreq_mem (stallreq_mem),
    .busy         (busy)
  );

  // 64 KiB RAM (low 16 address bits); contents held as XOR against a fixed pattern so
  // untouched bytes read back non-trivial values.
  bit [7:0] ram_x [0:65535];
  bit [7:0] ref_x [0:65535];

  function automatic logic [7:0] dflt(input logic [15:0] a);
    return {a[3:0], a[7:4]} ^ a[15:8] ^ 8'hC3;
  endfunction

  always @(posedge clk) begin
    if (ram_wr) ram_x[ram_addr[15:0]] <= ram_dout ^ dflt(ram_addr[15:0]);
    ram_din <= ram_x[ram_addr[15:0]] ^ dflt(ram_addr[15:0]);
  end

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_x[a[15:0]] ^ dflt(a[15:0]);
  endfunction

  task automatic ref_wr(input logic [31:0] a, input logic [7:0] d);
    ref_x[a[15:0]] = d ^ dflt(a[15:0]);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " ram_addr"}, ram_addr, 32'd0);
    chk({tag, " ram_wr"}, 32'(ram_wr), 32'd0);
    chk({tag, " ram_dout"}, 32'(ram_dout), 32'd0);
    chk({tag, " if_ready"}, 32'(if_ready), 32'd0);
    chk({tag, " mem_ready"}, 32'(mem_ready), 32'd0);
    chk({tag, " if_inst"}, if_inst, 32'd0);
    chk({tag, " mem_rdata"}, mem_rdata, 32'd0);
  endtask

  // One isolated transaction, starting at the drive point of its grant cycle T with the
  // arbiter idle; returns at the drive point of cycle T+lat+1 with the request dropped.
  task automatic run(input bit is_if, input bit we, input logic [1:0] size,
                     input logic [31:0] addr, input logic [31:0] wdata);
    int n, lat;
    logic [31:0] exp_d, ea;
    logic        ewr, inwin;
    string       t;
    n     = is_if ? 4 : (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    lat   = (we && !is_if) ? n + 1 : n + 2;
    exp_d = '0;
    for (int k = 0; k < n; k++) begin
      if (we && !is_if) ref_wr(addr + 32'(k), wdata[8*k +: 8]);
      else exp_d[8*k +: 8] = ref_rd(addr + 32'(k));
    end
    if (is_if) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      mem_req = 1'b1; mem_we = we; mem_size = size; mem_addr = addr; mem_wdata = wdata;
    end
    for (int c = 0; c <= lat; c++) begin
      if (c > 0) go();
      smp();
      t     = $sformatf("%s@%h c%0d", is_if ? "if" : we ? "st" : "ld", addr, c);
      inwin = (c >= 1) && (c <= n);
      ea    = inwin ? addr + 32'(c - 1) : 32'd0;
      ewr   = inwin && we && !is_if;
      chk({t, " ram_addr"}, ram_addr, ea);
      chk({t, " ram_wr"}, 32'(ram_wr), 32'(ewr));
      if (ewr) chk({t, " ram_dout"}, 32'(ram_dout), 32'(wdata[8*(c-1) +: 8]));
      else if (!inwin) chk({t, " ram_dout"}, 32'(ram_dout), 32'd0);
      chk({t, " busy"}, 32'(busy), 32'((c >= 1) && (c < lat)));
      chk({t, " if_ready"}, 32'(if_ready), 32'(is_if && (c == lat)));
      chk({t, " mem_ready"}, 32'(mem_ready), 32'(!is_if && (c == lat)));
      if (is_if) chk({t, " stallreq_if"}, 32'(stallreq_if), 32'(c != lat));
      else       chk({t, " stallreq_mem"}, 32'(stallreq_mem), 32'(c != lat));
    end
    if (is_if) last_inst = exp_d;
    else if (!we) last_rd = exp_d;
    chk({t, " if_inst"}, if_inst, last_inst);
    chk({t, " mem_rdata"}, mem_rdata, last_rd);
    go();
    if_req  = 1'b0;
    mem_req = 1'b0;
  endtask

  initial begin
    logic [31:0] fa, exp_i, ea;
    logic [31:0] a;
    int          kind;
    string       t;

    rst = 1'b0; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
    mem_size = '0; mem_addr = '0; mem_wdata = '0;
    go(); go();
    smp();
    chk_reset("reset");
    go();
    rst = 1'b1;
    go();

    // Word fetch of 0x00100513 (bytes 13,05,10,00), placed in RAM by a store first.
    run(1'b0, 1'b1, 2'd2, 32'h100, 32'h0010_0513);
    run(1'b1, 1'b0, 2'd2, 32'h100, 32'd0);
    chk("t1 if_inst", if_inst, 32'h0010_0513);

    // Simultaneous MEM byte load (0xFF) and IF fetch: MEM first, IF granted at T+4.
    run(1'b0, 1'b1, 2'd0, 32'h2000, 32'h0000_00FF);
    fa    = 32'h400;
    exp_i = {ref_rd(fa + 3), ref_rd(fa + 2), ref_rd(fa + 1), ref_rd(fa)};
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd0; mem_addr = 32'h2000;
    if_req = 1'b1; if_addr = fa;
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) go();
      if (c == 4) mem_req = 1'b0;
      smp();
      t  = $sformatf("t2 c%0d", c);
      ea = (c == 1) ? 32'h2000 : (c >= 5 && c <= 8) ? fa + 32'(c - 5) : 32'd0;
      chk({t, " ram_addr"}, ram_addr, ea);
      chk({t, " mem_ready"}, 32'(mem_ready), 32'(c == 3));
      chk({t, " if_ready"}, 32'(if_ready), 32'(c == 10));
      chk({t, " stallreq_if"}, 32'(stallreq_if), 32'(c != 10));
      chk({t, " busy"}, 32'(busy), 32'((c >= 1 && c <= 2) || (c >= 5 && c <= 9)));
      if (c == 3) chk("t2 mem_rdata", mem_rdata, 32'h0000_00FF);
    end
    chk("t2 if_inst", if_inst, exp_i);
    last_inst = exp_i;
    last_rd   = 32'h0000_00FF;
    go();
    if_req = 1'b0;

    // Store half across a 64 KiB boundary, then read the word back: upper bytes untouched.
    run(1'b0, 1'b1, 2'd1, 32'h0003_FFFF, 32'hABCD_1234);
    run(1'b0, 1'b0, 2'd2, 32'h0003_FFFF, 32'd0);

    // Fetch abort: if_req low during T+3, idle at T+4, then a fresh fetch granted at T+4.
    if_req = 1'b1; if_addr = 32'h600;
    for (int c = 0; c <= 3; c++) begin
      if (c > 0) go();
      if (c == 3) if_req = 1'b0;
      smp();
      t = $sformatf("t4 c%0d", c);
      chk({t, " ram_addr"}, ram_addr, (c >= 1) ? 32'h600 + 32'(c - 1) : 32'd0);
      chk({t, " if_ready"}, 32'(if_ready), 32'd0);
      chk({t, " busy"}, 32'(busy), 32'(c >= 1));
      chk({t, " if_inst"}, if_inst, last_inst);
    end
    go();
    run(1'b1, 1'b0, 2'd2, 32'h700, 32'd0);

    // Word load wrapping past the top of the address space.
    run(1'b0, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'd0);

    // Reset during T+3 of a word store: three bytes written, then everything cleared.
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2; mem_addr = 32'h7000;
    mem_wdata = 32'h1122_3344;
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) go();
      if (c == 3) rst = 1'b0;
      if (c == 4) begin rst = 1'b1; mem_req = 1'b0; end
      smp();
      t = $sformatf("t6 c%0d", c);
      if (c >= 1 && c <= 3) begin
        chk({t, " ram_addr"}, ram_addr, 32'h7000 + 32'(c - 1));
        chk({t, " ram_wr"}, 32'(ram_wr), 32'd1);
        chk({t, " ram_dout"}, 32'(ram_dout), 32'(mem_wdata[8*(c-1) +: 8]));
        chk({t, " mem_ready"}, 32'(mem_ready), 32'd0);
      end
    end
    chk_reset("t6 after reset");
    for (int k = 0; k < 3; k++) ref_wr(32'h7000 + 32'(k), mem_wdata[8*k +: 8]);
    last_inst = '0;
    last_rd   = '0;
    go();

    // Random traffic over a small window (plus the wrap region) checked against ref_x.
    for (int i = 0; i < 40; i++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) go();
      kind = $urandom_range(0, 2);
      a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                      : 32'h5000 + 32'($urandom_range(0, 31));
      run(kind == 0, kind == 2, 2'($urandom_range(0, 3)), a, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
